// File: rtl/pwm_multi_ch_if.sv
// Purpose: register-write and per-channel control/status bundle for pwm_multi_ch.
// Latency: n/a (signal grouping only); master drives writes/start/stop, slave drives PWM status.
// Backpressure: none; writes and start/stop are single-cycle strobes, always accepted.
interface pwm_multi_ch_if #(
    parameter int CHANNELS  = 4,
    parameter int TimerBits = 8,
    parameter int ADDR_W    = 4
);
    logic                 i_wr_en;
    logic [ADDR_W-1:0]    i_wr_addr;
    logic [TimerBits-1:0] i_wr_data;
    logic [CHANNELS-1:0]  i_start;
    logic [CHANNELS-1:0]  i_stop;
    logic [CHANNELS-1:0]  o_pwm;
    logic [CHANNELS-1:0]  o_busy;
    logic [CHANNELS-1:0]  o_done;
    logic [CHANNELS-1:0]  o_wrap;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop,
        input  o_pwm, o_busy, o_done, o_wrap
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_stop,
        output o_pwm, o_busy, o_done, o_wrap
    );
endinterface

// File: rtl/pwm_multi_ch.sv
// Purpose: N-channel PWM with shadowed TOP/DUTY/REP staging regs, bursts, start/stop per channel.
// Latency: outputs registered; o_busy/o_pwm valid the cycle after i_start, o_done the cycle after last wrap.
// Backpressure: none; register writes and start/stop strobes are accepted every cycle.
// Ports: i_clk, i_rst (sync, active-low); bus = write port (en/addr/data), start/stop,
//        and per-channel pwm/busy/done/wrap status.
module pwm_multi_ch #(
    parameter int CHANNELS  = 4,
    parameter int TimerBits = 8,
    parameter int CNT_BITS  = 8,
    parameter int ADDR_W    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pwm_multi_ch_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

    // Staging registers: written by the front end, only sampled at start or period boundaries.
    logic [TimerBits-1:0] top_r;
    logic [TimerBits-1:0] duty_r [CHANNELS];
    logic [CNT_BITS-1:0]  rep_r  [CHANNELS];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            top_r <= '0;
            for (int j = 0; j < CHANNELS; j++) begin
                duty_r[j] <= '0;
                rep_r[j]  <= '0;
            end
        end else if (bus.i_wr_en) begin
            if (bus.i_wr_addr == '0) begin
                top_r <= bus.i_wr_data;
            end
            for (int j = 0; j < CHANNELS; j++) begin
                if (bus.i_wr_addr == ADDR_W'(j + 1)) begin
                    duty_r[j] <= bus.i_wr_data;
                end
                if (bus.i_wr_addr == ADDR_W'(CHANNELS + j + 1)) begin
                    rep_r[j] <= CNT_BITS'(bus.i_wr_data);
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        st_t                  st_q, st_d;
        logic [TimerBits-1:0] cnt_q, cnt_d;
        logic [TimerBits-1:0] top_q, top_d;
        logic [TimerBits-1:0] duty_q, duty_d;
        logic [CNT_BITS-1:0]  pc_q, pc_d;
        logic [CNT_BITS-1:0]  rep_q, rep_d;
        logic                 done_d;
        logic                 last_period;
        logic                 pwm_q, busy_q, done_q, wrap_q;

        // One extra bit so pc+1 cannot wrap before being compared with REP.
        assign last_period = (rep_q != '0) &&
                             (({1'b0, pc_q} + (CNT_BITS + 1)'(1)) == {1'b0, rep_q});

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            top_d  = top_q;
            duty_d = duty_q;
            pc_d   = pc_q;
            rep_d  = rep_q;
            done_d = 1'b0;
            if (bus.i_stop[k]) begin
                // Stop dominates a same-cycle start; in IDLE it changes nothing.
                st_d = IDLE;
            end else if (bus.i_start[k]) begin
                st_d   = RUN;
                cnt_d  = '0;
                pc_d   = '0;
                top_d  = top_r;
                duty_d = duty_r[k];
                rep_d  = rep_r[k];
            end else if (st_q == RUN) begin
                if (cnt_q == top_q) begin
                    cnt_d = '0;
                    // Saturate so continuous mode never wraps the period count.
                    pc_d  = (pc_q == '1) ? pc_q : pc_q + CNT_BITS'(1);
                    if (last_period) begin
                        st_d   = IDLE;
                        done_d = 1'b1;
                    end else begin
                        top_d  = top_r;
                        duty_d = duty_r[k];
                    end
                end else begin
                    cnt_d = cnt_q + TimerBits'(1);
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                top_q  <= '0;
                duty_q <= '0;
                pc_q   <= '0;
                rep_q  <= '0;
                pwm_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                top_q  <= top_d;
                duty_q <= duty_d;
                pc_q   <= pc_d;
                rep_q  <= rep_d;
                // Outputs are registered from next-state values so they line up with cnt_q.
                pwm_q  <= (st_d == RUN) && (cnt_d < duty_d);
                busy_q <= (st_d == RUN);
                done_q <= done_d;
                wrap_q <= (st_d == RUN) && (cnt_d == top_d);
            end
        end

        assign bus.o_pwm[k]  = pwm_q;
        assign bus.o_busy[k] = busy_q;
        assign bus.o_done[k] = done_q;
        assign bus.o_wrap[k] = wrap_q;
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Purpose: directed self-checking bench for pwm_multi_ch (4 channels, 8-bit timer).
// Latency: checks outputs 1 time unit after each rising edge; inputs change on falling edges.
// Backpressure: n/a.
module tb_pwm_multi_ch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pwm_multi_ch_if #(.CHANNELS(4), .TimerBits(8), .ADDR_W(4)) bus ();

    pwm_multi_ch #(.CHANNELS(4), .TimerBits(8), .CNT_BITS(8), .ADDR_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       rn;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] start;
        logic [3:0] stop;
        logic [3:0] pwm;
        logic [3:0] busy;
        logic [3:0] done;
        logic [3:0] wrap;
    } vec_t;

    vec_t vecs [28];
    int   checks   = 0;
    int   failures = 0;
    int   e_pwm, e_wrap, e_busy, n_done, n_wrap, n_hi;
    int   hi [7];
    int   exp_d [7];

    function automatic vec_t mk(input logic rn, input logic we, input logic [3:0] a,
                                input logic [7:0] d, input logic [3:0] st, input logic [3:0] sp,
                                input logic [3:0] p, input logic [3:0] b, input logic [3:0] dn,
                                input logic [3:0] w);
        vec_t v;
        v.rn = rn; v.we = we; v.addr = a; v.data = d; v.start = st; v.stop = sp;
        v.pwm = p; v.busy = b; v.done = dn; v.wrap = w;
        return v;
    endfunction

    task automatic drive(input logic rn, input logic we, input logic [3:0] a,
                         input logic [7:0] d, input logic [3:0] st, input logic [3:0] sp);
        @(negedge clk);
        rst_n         = rn;
        bus.i_wr_en   = we;
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
        bus.i_start   = st;
        bus.i_stop    = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'd0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d, 4'd0, 4'd0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_start = '0;   bus.i_stop = '0;

        // TOP=3, DUTY0=2, REP0=3; shadow writes mid-period and on the wrap cycle.
        //               rn we addr data  start stop   pwm   busy  done  wrap
        vecs[0]  = mk(0, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[1]  = mk(1, 1, 4'd0, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[2]  = mk(1, 1, 4'd1, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mk(1, 1, 4'd5, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[4]  = mk(1, 0, 4'd0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[5]  = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[6]  = mk(1, 1, 4'd1, 8'd1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        vecs[7]  = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
        vecs[8]  = mk(1, 1, 4'd1, 8'd3, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[9]  = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        vecs[10] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        vecs[11] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
        vecs[12] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[13] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[14] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        vecs[15] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
        vecs[16] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
        vecs[17] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Ch3 with DUTY3=2: stop, start+stop, restart in RUN.
        vecs[18] = mk(1, 1, 4'd4, 8'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[19] = mk(1, 0, 4'd0, 8'd0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0);
        vecs[20] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[21] = mk(1, 0, 4'd0, 8'd0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[22] = mk(1, 0, 4'd0, 8'd0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0);
        vecs[23] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0);
        vecs[24] = mk(1, 0, 4'd0, 8'd0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0);
        vecs[25] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0);
        vecs[26] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0);
        vecs[27] = mk(1, 0, 4'd0, 8'd0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rn, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].start, vecs[i].stop);
            chk($sformatf("vec%0d_pwm", i),  32'(bus.o_pwm),  32'(vecs[i].pwm));
            chk($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(bus.o_done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_wrap", i), 32'(bus.o_wrap), 32'(vecs[i].wrap));
        end

        // Ch0 continuous, TOP=99, DUTY=50; DUTY=80 written at cnt=30 of period 3,
        // DUTY=10 written on the wrap cycle of period 4 (applies from period 6).
        exp_d = '{50, 50, 50, 50, 80, 80, 10};
        for (int p = 0; p < 7; p++) hi[p] = 0;
        wr(4'd0, 8'd99); wr(4'd1, 8'd50); wr(4'd5, 8'd0);
        e_pwm = 0; e_wrap = 0; e_busy = 0; n_done = 0; n_wrap = 0;
        for (int i = 0; i < 700; i++) begin
            if (i == 0)        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h1, 4'h0);
            else if (i == 331) wr(4'd1, 8'd80);
            else if (i == 500) wr(4'd1, 8'd10);
            else               idle();
            if (bus.o_pwm[0] !== (((i % 100) < exp_d[i / 100]) ? 1'b1 : 1'b0)) e_pwm++;
            if (bus.o_wrap[0] !== (((i % 100) == 99) ? 1'b1 : 1'b0)) e_wrap++;
            if (bus.o_busy[0] !== 1'b1) e_busy++;
            if (bus.o_done[0] !== 1'b0) n_done++;
            if (bus.o_wrap[0] === 1'b1) n_wrap++;
            if (bus.o_pwm[0] === 1'b1) hi[i / 100]++;
        end
        chk("cont_pwm_errs", e_pwm, 0);
        chk("cont_wrap_errs", e_wrap, 0);
        chk("cont_busy_errs", e_busy, 0);
        chk("cont_done_cnt", n_done, 0);
        chk("cont_wrap_cnt", n_wrap, 7);
        chk("shadow_p3_hi", hi[3], 50);
        chk("shadow_p4_hi", hi[4], 80);
        chk("wrapwr_p5_hi", hi[5], 80);
        chk("wrapwr_p6_hi", hi[6], 10);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h0, 4'h1);
        chk("cont_stop_busy", 32'(bus.o_busy[0]), 0);
        chk("cont_stop_done", 32'(bus.o_done[0]), 0);

        // Ch1 burst: REP=3, DUTY=25, TOP=99.
        wr(4'd2, 8'd25); wr(4'd6, 8'd3);
        n_hi = 0; e_busy = 0; n_done = 0; n_wrap = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h2, 4'h0);
            else        idle();
            if (bus.o_pwm[1] === 1'b1) n_hi++;
            if (bus.o_busy[1] !== 1'b1) e_busy++;
            if (bus.o_done[1] !== 1'b0) n_done++;
            if (bus.o_wrap[1] === 1'b1) n_wrap++;
        end
        chk("burst_hi", n_hi, 75);
        chk("burst_busy_errs", e_busy, 0);
        chk("burst_early_done", n_done, 0);
        chk("burst_wraps", n_wrap, 3);
        idle();
        chk("burst_done", 32'(bus.o_done[1]), 1);
        chk("burst_busy_end", 32'(bus.o_busy[1]), 0);
        chk("burst_pwm_end", 32'(bus.o_pwm[1]), 0);
        idle();
        chk("burst_done_1cyc", 32'(bus.o_done[1]), 0);

        // Ch2 edge duties.
        wr(4'd3, 8'd0);
        n_hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h4, 4'h0);
            else        idle();
            if (bus.o_pwm[2] === 1'b1) n_hi++;
        end
        chk("duty0_hi", n_hi, 0);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h0, 4'h4);
        wr(4'd3, 8'd200);
        n_hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h4, 4'h0);
            else        idle();
            if (bus.o_pwm[2] === 1'b1) n_hi++;
        end
        chk("duty200_hi", n_hi, 200);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h0, 4'h4);
        wr(4'd0, 8'd0); wr(4'd3, 8'd1);
        n_hi = 0; n_wrap = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h4, 4'h0);
            else        idle();
            if (bus.o_pwm[2] === 1'b1) n_hi++;
            if (bus.o_wrap[2] === 1'b1) n_wrap++;
        end
        chk("top0_hi", n_hi, 20);
        chk("top0_wrap", n_wrap, 20);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'h0, 4'h4);

        // Reset while all four channels run.
        wr(4'd0, 8'd9);
        for (int c = 1; c <= 4; c++) wr(4'(c), 8'd5);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'hF, 4'h0);
        for (int i = 0; i < 4; i++) idle();
        chk("pre_rst_busy", 32'(bus.o_busy), 32'hF);
        drive(1'b0, 1'b0, 4'd0, 8'd0, 4'h0, 4'h0);
        chk("rst_pwm", 32'(bus.o_pwm), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_wrap", 32'(bus.o_wrap), 0);
        idle();
        chk("post_rst_done", 32'(bus.o_done), 0);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 4'hF, 4'h0);
        chk("rst_restart_pwm", 32'(bus.o_pwm), 0);
        chk("rst_restart_busy", 32'(bus.o_busy), 32'hF);
        chk("rst_restart_wrap", 32'(bus.o_wrap), 32'hF);
        e_pwm = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (bus.o_pwm !== 4'h0) e_pwm++;
        end
        chk("rst_restart_pwm_run", e_pwm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
